network_interface: RTL and testbench

//  Network interface controller (NIC) that sits between a processing element and the router's PE port.
//  The PE injects packets into the mesh through a memory-mapped output buffer and collects delivered

---
 rtl/nic_pkg.sv | 12 +
 rtl/nic_fifo.sv | 55 +++++
 rtl/network_interface.sv | 79 +++++++
 tb/tb_network_interface.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
// Shared constants for the network interface: packet geometry and PE register map.
package nic_pkg;

    localparam int DATA_W = 64;
    localparam int VC_BIT = 63;

    localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_fifo.sv
// Small synchronous FIFO with occupancy count; pushes while full and pops while empty are ignored.
module nic_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SLOTS = 2 ** PW;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [SLOTS];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign head   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/network_interface.sv
// NIC between a PE and a router port: memory-mapped out/in packet buffers with polarity-gated injection.
module network_interface #(
    parameter int DATA_W = nic_pkg::DATA_W,
    parameter int VC_BIT = nic_pkg::VC_BIT,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_ro,
    input  logic              net_si,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_ri,
    input  logic              net_polarity
);
    import nic_pkg::*;

    logic [DATA_W-1:0] r_d_out;
    logic [DATA_W-1:0] w_out_head;
    logic [DATA_W-1:0] w_in_head;
    logic              w_out_full, w_out_empty;
    logic              w_in_full, w_in_empty;
    logic              w_pe_wr, w_pe_rd;
    logic              w_out_push, w_in_pop, w_in_push;

    assign w_pe_wr    = nicEn & nicWrEn;
    assign w_pe_rd    = nicEn & ~nicWrEn;
    assign w_out_push = w_pe_wr & (addr == ADDR_OUT_DATA);
    assign w_in_pop   = w_pe_rd & (addr == ADDR_IN_DATA);

    // Injection only depends on buffer state and router-side inputs, never on PE address/data.
    assign net_so    = ~w_out_empty & net_ro & (w_out_head[VC_BIT] == net_polarity);
    assign net_do    = w_out_head;
    assign net_ri    = ~w_in_full;
    assign w_in_push = net_si & net_ri;
    assign d_out     = r_d_out;

    nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (w_out_push),
        .pop   (net_so),
        .din   (d_in),
        .head  (w_out_head),
        .full  (w_out_full),
        .empty (w_out_empty)
    );

    nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (w_in_push),
        .pop   (w_in_pop),
        .din   (net_di),
        .head  (w_in_head),
        .full  (w_in_full),
        .empty (w_in_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_out <= '0;
        end else if (w_pe_rd) begin
            case (addr)
                ADDR_IN_DATA:  r_d_out <= w_in_empty ? '0 : w_in_head;
                ADDR_IN_STAT:  r_d_out <= {{(DATA_W-1){1'b0}}, w_in_full};
                ADDR_OUT_STAT: r_d_out <= {{(DATA_W-1){1'b0}}, w_out_full};
                default:       r_d_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_network_interface.sv
// Bench for network_interface: directed scenarios on a 1-deep NIC, randomized traffic on 1- and 4-deep NICs.
module tb_network_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic        nicEn, nicWrEn;
    logic        net_ro, net_si, net_polarity;
    logic [63:0] net_di;

    logic [63:0] d_out1, net_do1, d_out4, net_do4;
    logic        net_so1, net_ri1, net_so4, net_ri4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    network_interface #(.DATA_W(64), .VC_BIT(63), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out1),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so1), .net_do(net_do1),
        .net_ro(net_ro), .net_si(net_si), .net_di(net_di), .net_ri(net_ri1),
        .net_polarity(net_polarity)
    );

    network_interface #(.DATA_W(64), .VC_BIT(63), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out4),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so4), .net_do(net_do4),
        .net_ro(net_ro), .net_si(net_si), .net_di(net_di), .net_ri(net_ri4),
        .net_polarity(net_polarity)
    );

    // All stimulus tasks start and end just after a falling edge.
    task automatic pe_write(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic pe_read(input logic [1:0] a, output logic [63:0] v1, output logic [63:0] v4);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        @(negedge clk);
        nicEn = 1'b0;
        v1 = d_out1;
        v4 = d_out4;
    endtask

    task automatic router_send(input logic [63:0] d);
        net_si = 1'b1; net_di = d;
        @(negedge clk);
        net_si = 1'b0;
    endtask

    task automatic do_reset();
        nicEn = 0; nicWrEn = 0; addr = 0; d_in = 0;
        net_ro = 0; net_si = 0; net_di = 0; net_polarity = 0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [63:0] v1, v4;
        net_ro = 1'b0;
        pe_write(2'b10, 64'h0000_0000_0000_0055);
        router_send(64'h0000_0000_0000_0077);
        total++; if (net_ri1 !== 1'b0) $display("FAIL pre_reset_ri got %b exp 0", net_ri1); else passed++;
        pe_read(2'b11, v1, v4);
        total++; if (v1 !== 64'd1) $display("FAIL pre_reset_outfull got %h exp 1", v1); else passed++;
        net_ro = 1'b1; net_polarity = 1'b0;
        #1;
        total++; if (net_so1 !== 1'b1) $display("FAIL pre_reset_so got %b exp 1", net_so1); else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++; if (net_ri1 !== 1'b1) $display("FAIL reset_ri got %b exp 1", net_ri1); else passed++;
        total++; if (net_so1 !== 1'b0) $display("FAIL reset_so got %b exp 0", net_so1); else passed++;
        total++; if (net_do1 !== 64'd0) $display("FAIL reset_do got %h exp 0", net_do1); else passed++;
        total++; if (d_out1 !== 64'd0) $display("FAIL reset_dout got %h exp 0", d_out1); else passed++;
        reset = 1'b1;
        @(negedge clk);
        pe_read(2'b01, v1, v4);
        total++; if (v1 !== 64'd0) $display("FAIL reset_instat got %h exp 0", v1); else passed++;
        pe_read(2'b11, v1, v4);
        total++; if (v1 !== 64'd0) $display("FAIL reset_outstat got %h exp 0", v1); else passed++;
        net_ro = 1'b0;
    endtask

    task automatic test_polarity();
        logic [63:0] v1, v4;
        logic [63:0] pkt;
        pkt = 64'h8000_0000_0000_00AA;
        net_ro = 1'b1; net_polarity = 1'b0;
        pe_write(2'b10, pkt);
        total++; if (net_so1 !== 1'b0) $display("FAIL pol_block got %b exp 0", net_so1); else passed++;
        @(negedge clk);
        total++; if (net_so1 !== 1'b0) $display("FAIL pol_hold got %b exp 0", net_so1); else passed++;
        net_polarity = 1'b1;
        #1;
        total++; if (net_so1 !== 1'b1) $display("FAIL pol_send got %b exp 1", net_so1); else passed++;
        total++; if (net_do1 !== pkt) $display("FAIL pol_data got %h exp %h", net_do1, pkt); else passed++;
        @(negedge clk);
        net_polarity = 1'b0;
        total++; if (net_so1 !== 1'b0) $display("FAIL pol_once got %b exp 0", net_so1); else passed++;
        pe_read(2'b11, v1, v4);
        total++; if (v1 !== 64'd0) $display("FAIL pol_outstat got %h exp 0", v1); else passed++;
        net_ro = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] v1, v4;
        logic [63:0] p1, p2;
        p1 = 64'h0000_0000_0000_0011;
        p2 = 64'h0000_0000_0000_0022;
        net_ro = 1'b0; net_polarity = 1'b0;
        pe_write(2'b10, p1);
        pe_write(2'b10, p2);
        pe_read(2'b11, v1, v4);
        total++; if (v1 !== 64'd1) $display("FAIL b2b_full got %h exp 1", v1); else passed++;
        net_ro = 1'b1;
        #1;
        total++; if (net_so1 !== 1'b1) $display("FAIL b2b_send got %b exp 1", net_so1); else passed++;
        total++; if (net_do1 !== p1) $display("FAIL b2b_data got %h exp %h", net_do1, p1); else passed++;
        @(negedge clk);
        total++; if (net_so1 !== 1'b0) $display("FAIL b2b_dropped got %b exp 0", net_so1); else passed++;
        net_ro = 1'b0;
    endtask

    task automatic test_eject();
        logic [63:0] v1, v4;
        router_send(64'h1234);
        total++; if (net_ri1 !== 1'b0) $display("FAIL ej_ri_low got %b exp 0", net_ri1); else passed++;
        pe_read(2'b01, v1, v4);
        total++; if (v1 !== 64'd1) $display("FAIL ej_instat got %h exp 1", v1); else passed++;
        pe_read(2'b00, v1, v4);
        total++; if (v1 !== 64'h1234) $display("FAIL ej_data got %h exp 1234", v1); else passed++;
        total++; if (net_ri1 !== 1'b1) $display("FAIL ej_ri_back got %b exp 1", net_ri1); else passed++;
    endtask

    task automatic test_empty_read();
        logic [63:0] v1, v4;
        pe_read(2'b00, v1, v4);
        total++; if (v1 !== 64'd0) $display("FAIL er_data got %h exp 0", v1); else passed++;
        total++; if (v4 !== 64'd0) $display("FAIL er_data4 got %h exp 0", v4); else passed++;
        pe_read(2'b01, v1, v4);
        total++; if (v1 !== 64'd0) $display("FAIL er_stat got %h exp 0", v1); else passed++;
        router_send(64'hA1);
        pe_read(2'b00, v1, v4);
        total++; if (v1 !== 64'hA1) $display("FAIL er_order_a got %h exp a1", v1); else passed++;
        total++; if (v4 !== 64'hA1) $display("FAIL er_order_a4 got %h exp a1", v4); else passed++;
        router_send(64'hB2);
        pe_read(2'b00, v1, v4);
        total++; if (v1 !== 64'hB2) $display("FAIL er_order_b got %h exp b2", v1); else passed++;
        total++; if (v4 !== 64'hB2) $display("FAIL er_order_b4 got %h exp b2", v4); else passed++;
    endtask

    // Reference: two bounded queues plus the last PE read value.
    task automatic test_random(input int depth, input int cycles);
        logic [63:0] oq[$];
        logic [63:0] iq[$];
        logic [63:0] exp_dout;
        logic        dout_known;
        logic        exp_so, exp_ri, o_full, i_full;
        logic [63:0] exp_do, so_d, do_d, dout_d;
        logic        so_v, ri_v;
        do_reset();
        exp_dout = 64'd0;
        dout_known = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            so_v   = (depth == 1) ? net_so1 : net_so4;
            do_d   = (depth == 1) ? net_do1 : net_do4;
            ri_v   = (depth == 1) ? net_ri1 : net_ri4;
            dout_d = (depth == 1) ? d_out1  : d_out4;
            exp_so = (oq.size() > 0) && net_ro && (oq[0][63] == net_polarity);
            exp_do = (oq.size() > 0) ? oq[0] : 64'd0;
            exp_ri = (iq.size() < depth);
            total++; if (so_v !== exp_so) $display("FAIL rnd_so d%0d c%0d got %b exp %b", depth, c, so_v, exp_so); else passed++;
            total++; if (do_d !== exp_do) $display("FAIL rnd_do d%0d c%0d got %h exp %h", depth, c, do_d, exp_do); else passed++;
            total++; if (ri_v !== exp_ri) $display("FAIL rnd_ri d%0d c%0d got %b exp %b", depth, c, ri_v, exp_ri); else passed++;
            if (dout_known) begin
                total++; if (dout_d !== exp_dout) $display("FAIL rnd_dout d%0d c%0d got %h exp %h", depth, c, dout_d, exp_dout); else passed++;
            end

            nicEn        = ($urandom_range(0, 9) < 7);
            nicWrEn      = $urandom_range(0, 1);
            addr         = 2'($urandom_range(0, 3));
            d_in         = {$urandom, $urandom};
            net_ro       = $urandom_range(0, 1);
            net_polarity = $urandom_range(0, 1);
            net_di       = {$urandom, $urandom};
            net_si       = $urandom_range(0, 1) && (iq.size() < depth);

            o_full = (oq.size() == depth);
            i_full = (iq.size() == depth);
            so_d   = {63'd0, (oq.size() > 0) && net_ro && (oq[0][63] == net_polarity)};
            if (nicEn && !nicWrEn) begin
                dout_known = 1'b1;
                case (addr)
                    2'b00:   exp_dout = (iq.size() > 0) ? iq.pop_front() : 64'd0;
                    2'b01:   exp_dout = {63'd0, i_full};
                    2'b11:   exp_dout = {63'd0, o_full};
                    default: dout_known = 1'b0;
                endcase
            end
            if (so_d[0]) void'(oq.pop_front());
            if (nicEn && nicWrEn && addr == 2'b10 && !o_full) oq.push_back(d_in);
            if (net_si && !i_full) iq.push_back(net_di);
            @(negedge clk);
        end
        nicEn = 0; net_si = 0; net_ro = 0;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_polarity();
        test_back_to_back();
        do_reset();
        test_eject();
        test_empty_read();
        test_random(1, 400);
        test_random(4, 600);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
